// File: rtl/gb_oam_dma_arbiter.sv
// gb_oam_dma_arbiter
// Owns the system memory bus between gb_cpu and the memory map and runs the
// OAM DMA engine behind register FF46. A write to FF46 copies DMA_LEN bytes
// from {FF46, 8'h00} to OAM_BASE. While the copy runs, the CPU can only reach
// HRAM (FF80-FFFE) and FF46.
//
// Optional feature macro: GB_DMA_RESTART_EN
//   defined   : an FF46 write during a transfer reloads the source and
//               restarts the copy from byte 0.
//   undefined : an FF46 write during a transfer is ignored completely.
module gb_oam_dma_arbiter #(
  parameter logic [15:0] OAM_BASE = 16'hFE00,
  parameter int unsigned DMA_LEN  = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  input  logic        cpu_we_i,
  output logic [7:0]  cpu_rdata_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        mem_we_o,
  input  logic [7:0]  mem_rdata_i,
  output logic        dma_active_o
);

  localparam logic [15:0] FF46_ADDR = 16'hFF46;
  localparam logic [15:0] HRAM_LO   = 16'hFF80;
  localparam logic [15:0] HRAM_HI   = 16'hFFFE;
  localparam logic [7:0]  LAST_IDX  = 8'(DMA_LEN - 32'd1);
  localparam logic [7:0]  LOCKED_RD = 8'hFF;

`ifdef GB_DMA_RESTART_EN
  localparam logic RESTART_EN = 1'b1;
`else
  localparam logic RESTART_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // HRAM stays reachable by the CPU while a transfer is running.
  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_LO) && (addr <= HRAM_HI);
  endfunction

  state_t      state_r;
  logic [7:0]  src_hi_r;
  logic [7:0]  idx_r;
  logic [7:0]  buf_r;
  logic        dma_active_r;

  logic        ff46_sel_s;
  logic        ff46_wr_s;
  logic        hram_sel_s;
  logic        busy_s;
  logic        restart_s;
  logic [15:0] oam_addr_s;
  logic [15:0] src_addr_s;

  assign ff46_sel_s   = (cpu_addr_i == FF46_ADDR);
  assign ff46_wr_s    = ff46_sel_s & cpu_we_i;
  assign hram_sel_s   = is_hram(cpu_addr_i);
  assign busy_s       = (state_r != ST_IDLE);
  assign restart_s    = RESTART_EN & busy_s & ff46_wr_s;
  assign oam_addr_s   = OAM_BASE + {8'h00, idx_r};
  assign src_addr_s   = {src_hi_r, idx_r};
  assign dma_active_o = dma_active_r;

  // Bus steering: CPU passthrough when idle or in HRAM, DMA owns it otherwise.
  always_comb begin
    mem_addr_o  = cpu_addr_i;
    mem_wdata_o = cpu_wdata_i;
    mem_we_o    = 1'b0;
    cpu_rdata_o = mem_rdata_i;
    if (reset) begin
      mem_we_o = 1'b0;
    end else if (!busy_s || hram_sel_s) begin
      // FF46 is decoded here and never reaches the memory map.
      mem_we_o    = cpu_we_i & ~ff46_sel_s;
      cpu_rdata_o = ff46_sel_s ? src_hi_r : mem_rdata_i;
    end else begin
      // Locked-out CPU: reads float high, writes vanish, FF46 still works.
      cpu_rdata_o = ff46_sel_s ? src_hi_r : LOCKED_RD;
      case (state_r)
        ST_START: begin
          mem_addr_o  = {src_hi_r, 8'h00};
          mem_wdata_o = buf_r;
          mem_we_o    = 1'b0;
        end
        ST_READ: begin
          mem_addr_o  = src_addr_s;
          mem_wdata_o = buf_r;
          mem_we_o    = 1'b0;
        end
        ST_WRITE: begin
          mem_addr_o  = oam_addr_s;
          mem_wdata_o = buf_r;
          mem_we_o    = 1'b1;
        end
        default: begin
          mem_we_o = 1'b0;
        end
      endcase
    end
  end

  // DMA sequencer: FF46 register, byte index, data buffer and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      src_hi_r     <= 8'hFF;
      idx_r        <= 8'h00;
      buf_r        <= 8'h00;
      dma_active_r <= 1'b0;
    end else if (restart_s) begin
      // New source mid-transfer: start over, busy flag never drops.
      src_hi_r     <= cpu_wdata_i;
      idx_r        <= 8'h00;
      state_r      <= ST_START;
      dma_active_r <= 1'b1;
    end else if (busy_s && hram_sel_s) begin
      // CPU took the bus for an HRAM access; freeze the transfer one cycle.
      state_r      <= state_r;
      idx_r        <= idx_r;
      buf_r        <= buf_r;
      dma_active_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ff46_wr_s) begin
            src_hi_r     <= cpu_wdata_i;
            state_r      <= ST_START;
            dma_active_r <= 1'b1;
          end else begin
            state_r      <= ST_IDLE;
            dma_active_r <= 1'b0;
          end
        end
        ST_START: begin
          idx_r   <= 8'h00;
          state_r <= ST_READ;
        end
        ST_READ: begin
          buf_r   <= mem_rdata_i;
          state_r <= ST_WRITE;
        end
        ST_WRITE: begin
          if (idx_r == LAST_IDX) begin
            state_r      <= ST_IDLE;
            dma_active_r <= 1'b0;
          end else begin
            idx_r   <= idx_r + 8'd1;
            state_r <= ST_READ;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          dma_active_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gb_oam_dma_arbiter.sv
// Self-checking bench for gb_oam_dma_arbiter. Memory-bus writes are checked by
// a scoreboard monitor against an expected-write queue filled by the stimulus;
// combinational read paths and busy durations are checked inline.
module tb_gb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr_i = 16'h0000;
  logic [7:0]  cpu_wdata_i = 8'h00;
  logic        cpu_we_i = 1'b0;
  logic [7:0]  cpu_rdata_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_we_o;
  logic [7:0]  mem_rdata_i;
  logic        dma_active_o;

  // Bench-owned memory with a private preload port.
  logic [7:0]  mem [0:65535];
  logic        tb_we = 1'b0;
  logic [15:0] tb_addr = 16'h0000;
  logic [7:0]  tb_data = 8'h00;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gb_oam_dma_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_we_o     (mem_we_o),
    .mem_rdata_i  (mem_rdata_i),
    .dma_active_o (dma_active_o)
  );

  assign mem_rdata_i = mem[mem_addr_o];

  always @(posedge clk) begin
    if (mem_we_o === 1'b1) mem[mem_addr_o] <= mem_wdata_o;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every bus write must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL bus_write: got write %h=%h, required no write", mem_addr_o, mem_wdata_o);
      end else begin
        e = exp_q.pop_front();
        check("bus_addr", {16'h0, mem_addr_o}, {16'h0, e.a});
        check("bus_data", {24'h0, mem_wdata_o}, {24'h0, e.d});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] src_val(input logic [7:0] hi, input int i);
    logic [7:0] b;
    b = 8'(i);
    if (hi == 8'hC0) return b ^ 8'hA5;
    else return 8'(b * 8'd7 + 8'd3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cpu_addr_i  = 16'h0000;
    cpu_wdata_i = 8'h00;
    cpu_we_i    = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr_i = a; cpu_wdata_i = d; cpu_we_i = 1'b1;
    tick();
    idle_bus();
  endtask

  task automatic cpu_rd_check(input string name, input logic [15:0] a, input logic [7:0] req);
    cpu_addr_i = a; cpu_we_i = 1'b0;
    #1;
    check(name, {24'h0, cpu_rdata_o}, {24'h0, req});
    tick();
    idle_bus();
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 160; i++) poke(16'hFE00 + 16'(i), 8'hEE);
  endtask

  task automatic push_copy(input logic [7:0] hi, input int lo, input int last);
    wr_t w;
    for (int i = lo; i <= last; i++) begin
      w.a = 16'hFE00 + 16'(i);
      w.d = src_val(hi, i);
      exp_q.push_back(w);
    end
  endtask

  task automatic check_oam(input string name, input logic [7:0] hi, input int lo, input int last);
    for (int i = lo; i <= last; i++)
      check(name, {24'h0, mem[16'hFE00 + 16'(i)]}, {24'h0, src_val(hi, i)});
  endtask

  // Cycle 1 is the START cycle; events fire in the numbered busy cycle.
  task automatic dma_run(input int hram_c, input int lock_c, input int ff46_c,
                         input int rst_c, output int busy);
    int c;
    c = 1;
    while (dma_active_o === 1'b1 && c < 1000) begin
      idle_bus();
      if (c == hram_c) begin
        cpu_addr_i = 16'hFF90; cpu_wdata_i = 8'h77; cpu_we_i = 1'b1;
      end
      if (c == lock_c) begin
        cpu_addr_i = 16'h0150;
        #1;
        check("lock_rdata", {24'h0, cpu_rdata_o}, 32'h0000_00FF);
        check("lock_addr_hidden", {31'h0, mem_addr_o == 16'h0150}, 32'h0);
      end
      if (c == lock_c + 1) begin
        cpu_addr_i = 16'hC000; cpu_wdata_i = 8'h11; cpu_we_i = 1'b1;
      end
      if (c == ff46_c) begin
        cpu_addr_i = 16'hFF46; cpu_wdata_i = 8'hD0; cpu_we_i = 1'b1;
      end
      if (c == rst_c) reset = 1'b1;
      tick();
      c++;
    end
    idle_bus();
    if (c >= 1000) begin
      n_vec++;
      n_err++;
      $display("FAIL dma_timeout: got busy >= %0d cycles, required completion", c);
    end
    busy = c - 1;
  endtask

  initial begin
    int busy;
    wr_t w;

    // Reset behaviour.
    reset = 1'b1;
    idle_bus();
    tick();
    tick();
    poke(16'h1234, 8'h9E);
    cpu_addr_i = 16'h1234; cpu_wdata_i = 8'hAB; cpu_we_i = 1'b1;
    #1;
    check("rst_active", {31'h0, dma_active_o}, 32'h0);
    check("rst_we", {31'h0, mem_we_o}, 32'h0);
    check("rst_addr", {16'h0, mem_addr_o}, 32'h0000_1234);
    check("rst_wdata", {24'h0, mem_wdata_o}, 32'h0000_00AB);
    check("rst_rdata", {24'h0, cpu_rdata_o}, 32'h0000_009E);
    tick();
    idle_bus();
    reset = 1'b0;
    tick();
    check("rst_no_write", {24'h0, mem[16'h1234]}, 32'h0000_009E);
    cpu_rd_check("ff46_reset", 16'hFF46, 8'hFF);

    // Idle passthrough.
    cpu_addr_i = 16'hC000; cpu_wdata_i = 8'h5A; cpu_we_i = 1'b1;
    #1;
    check("pt_we", {31'h0, mem_we_o}, 32'h1);
    check("pt_addr", {16'h0, mem_addr_o}, 32'h0000_C000);
    check("pt_wdata", {24'h0, mem_wdata_o}, 32'h0000_005A);
    w.a = 16'hC000; w.d = 8'h5A;
    exp_q.push_back(w);
    tick();
    idle_bus();
    cpu_rd_check("pt_read", 16'hC000, 8'h5A);

    // Source data and OAM markers.
    for (int i = 0; i < 160; i++) poke(16'hC000 + 16'(i), src_val(8'hC0, i));
    for (int i = 0; i < 160; i++) poke(16'hD000 + 16'(i), src_val(8'hD0, i));
    clear_oam();
    poke(16'hFEA0, 8'h3C);

    // Full copy with lockout accesses at cycles 30 and 31.
    push_copy(8'hC0, 0, 159);
    cpu_wr(16'hFF46, 8'hC0);
    dma_run(-5, 30, -5, -5, busy);
    check("full_busy", busy, 32'd321);
    check_oam("full_oam", 8'hC0, 0, 159);
    check("full_fea0", {24'h0, mem[16'hFEA0]}, 32'h0000_003C);
    check("lock_write_dropped", {24'h0, mem[16'hC000]}, 32'h0000_00A5);
    cpu_rd_check("full_ff46", 16'hFF46, 8'hC0);

    // HRAM write during byte 10 READ (cycle 22) stalls one cycle.
    clear_oam();
    poke(16'hFF90, 8'h00);
    push_copy(8'hC0, 0, 9);
    w.a = 16'hFF90; w.d = 8'h77;
    exp_q.push_back(w);
    push_copy(8'hC0, 10, 159);
    cpu_wr(16'hFF46, 8'hC0);
    dma_run(22, -5, -5, -5, busy);
    check("hram_busy", busy, 32'd322);
    check("hram_data", {24'h0, mem[16'hFF90]}, 32'h0000_0077);
    check_oam("hram_oam", 8'hC0, 0, 159);

    // FF46 write in cycle 81 (byte 39 WRITE), i.e. after 40 bytes.
    clear_oam();
`ifdef GB_DMA_RESTART_EN
    push_copy(8'hC0, 0, 39);
    push_copy(8'hD0, 0, 159);
`else
    push_copy(8'hC0, 0, 159);
`endif
    cpu_wr(16'hFF46, 8'hC0);
    dma_run(-5, -5, 81, -5, busy);
`ifdef GB_DMA_RESTART_EN
    check("restart_busy", busy, 32'd402);
    check_oam("restart_oam", 8'hD0, 0, 159);
    cpu_rd_check("restart_ff46", 16'hFF46, 8'hD0);
`else
    check("norestart_busy", busy, 32'd321);
    check_oam("norestart_oam", 8'hC0, 0, 159);
    cpu_rd_check("norestart_ff46", 16'hFF46, 8'hC0);
`endif

    // Reset during byte 80 READ (cycle 162).
    clear_oam();
    push_copy(8'hC0, 0, 79);
    cpu_wr(16'hFF46, 8'hC0);
    dma_run(-5, -5, -5, 162, busy);
    reset = 1'b0;
    check("rst_mid_busy", busy, 32'd162);
    check("rst_mid_active", {31'h0, dma_active_o}, 32'h0);
    cpu_rd_check("rst_mid_ff46", 16'hFF46, 8'hFF);
    for (int i = 0; i < 20; i++) tick();
    check_oam("rst_mid_done", 8'hC0, 0, 79);
    for (int i = 80; i < 160; i++)
      check("rst_mid_kept", {24'h0, mem[16'hFE00 + 16'(i)]}, 32'h0000_00EE);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gb_oam_dma_arbiter.md
# gb_oam_dma_arbiter

Owns the single system memory bus between `gb_cpu` and the memory map, and implements the OAM DMA engine behind register FF46. A CPU write to FF46 starts a 160-byte copy from `{FF46, 8'h00}` to FE00–FE9F. While the copy runs, the block locks the CPU out of everything except HRAM (FF80–FFFE) and the FF46 register. It sits directly between the CPU bus pins (`addr_o`/`data_o`/`drive_data_bus`/`data_i`) and the memory/peripheral decode.

## Interface
- `OAM_BASE`, 16'hFE00, destination base address.
- `DMA_LEN`, 160, number of bytes per transfer.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_addr_i`  in  16  CPU address (`gb_cpu.addr_o`).
- `cpu_wdata_i`  in  8  CPU write data (`gb_cpu.data_o`).
- `cpu_we_i`  in  1  CPU write strobe (`gb_cpu.drive_data_bus`).
- `cpu_rdata_o`  out  8  read data to the CPU (`gb_cpu.data_i`).
- `mem_addr_o`  out  16  memory bus address.
- `mem_wdata_o`  out  8  memory bus write data.
- `mem_we_o`  out  1  memory bus write enable.
- `mem_rdata_i`  in  8  memory bus read data (combinational, same cycle).
- `dma_active_o`  out  1  high while a transfer is pending or running.

## Operation
- Registers:
  - `src_hi[7:0]`: the FF46 value, reset 8'hFF.
  - `idx[7:0]`: reset 0.
  - `buf[7:0]`: reset 0.
  - State machine: IDLE, START, READ, WRITE.
- FF46 decode is internal and never forwarded:
  - `cpu_addr_i==16'hFF46`: a read returns `src_hi`.
  - A write loads `src_hi`; `mem_we_o` stays 0.
- IDLE:
  - Full passthrough: `mem_addr_o=cpu_addr_i`, `mem_wdata_o=cpu_wdata_i`, `mem_we_o=cpu_we_i`, `cpu_rdata_o=mem_rdata_i`.
  - An FF46 write moves to START.
- START:
  - One delay cycle; `idx` is cleared.
  - The CPU is already locked out; the bus idles with `mem_we_o=0` unless HRAM is being accessed.
- READ:
  - `mem_addr_o={src_hi, idx}`, `mem_we_o=0`; `buf<=mem_rdata_i`; then WRITE.
- WRITE:
  - `mem_addr_o=OAM_BASE+idx`, `mem_wdata_o=buf`, `mem_we_o=1`.
  - If `idx==DMA_LEN-1`, go to IDLE; otherwise `idx++` and go to READ.
- CPU access while not IDLE:
  - HRAM (FF80–FFFE): the CPU owns the bus that cycle with passthrough as in IDLE. The DMA holds its state and `idx` (a 1-cycle stall), and `buf` is not loaded.
  - FF46: serviced internally, no stall.
  - Any other address: the read returns 8'hFF and the write is dropped. The DMA proceeds.
- `src_hi` is used verbatim for every value (no echo remap).
- Reset mid-transfer: the transfer is abandoned, the state returns to IDLE, and there are no further DMA writes.

## Timing
- FF46 write sampled at edge E0:
  - START is the cycle after E0.
  - Byte *i* READ/WRITE occur in cycles 2+2i and 3+2i (no stalls).
  - The last WRITE is in cycle 321.
- `dma_active_o` is registered:
  - It is 1 from the cycle after E0 through the last WRITE cycle, and 0 the next cycle.
  - Each HRAM stall adds one cycle.
- All `mem_*` and `cpu_rdata_o` outputs are combinational from state, registers and inputs.
- Reset values:
  - `dma_active_o=0`.
  - While `reset` is high: `mem_we_o=0`, `mem_addr_o=cpu_addr_i`, `mem_wdata_o=cpu_wdata_i`, `cpu_rdata_o=mem_rdata_i`.
- A CPU write to OAM in the same cycle as a DMA WRITE is dropped, because OAM is not HRAM.

## Configuration
- `GB_DMA_RESTART_EN` defined:
  - An FF46 write while not IDLE loads `src_hi` and forces START; `idx` restarts at 0 from the new source.
  - `dma_active_o` stays high across the restart.
- Not defined:
  - An FF46 write while not IDLE is ignored entirely: `src_hi` is unchanged and the transfer continues.
  - An FF46 write while IDLE behaves normally.

## Test plan
- Idle passthrough:
  - Write 8'h5A to C000 → `mem_we_o=1`, `mem_addr_o=C000`, `mem_wdata_o=5A`.
  - Read C000 → `cpu_rdata_o=5A`.
  - Read FF46 after reset → FF.
- Full copy:
  - Preload C000+i = i^8'hA5, then write C0 to FF46.
  - `dma_active_o` is high for exactly 321 cycles.
  - FE00+i = i^A5 for i=0..159, FEA0 is untouched, and FF46 reads C0.
- Lockout:
  - During DMA, read 0150 → `cpu_rdata_o=FF` with no memory-side CPU address.
  - Write 11 to C000 → the memory is unchanged.
- HRAM during DMA: write 77 to FF90 during a READ phase → FF90=77, `dma_active_o` is high for 322 cycles, and OAM contents are still correct.
- Restart at byte 40: write D0 to FF46.
  - With `GB_DMA_RESTART_EN`: FE00–FE9F equal D000–D09F, and the busy time totals 81+1+320 cycles.
  - Without it: FE00–FE9F equal C000–C09F and FF46 reads C0.
- Reset mid-DMA at byte 80:
  - `dma_active_o=0` the next cycle and FF46 reads FF.
  - FE50–FE9F keep their prior values.
